// File: rtl/umem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package umem_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_F = 1'b1;

  localparam int CNT_W       = 4;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way pick between the data port (bit 0) and fetch port (bit 1); one-hot grant.
// UMEM_ARB_FIXED_PRIO_EN selects fixed D-over-F priority instead of round-robin.
module arb_rr2
  import umem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef UMEM_ARB_FIXED_PRIO_EN
  logic last_unused;
  assign last_unused = last;
`endif

  // Winner selection; on a tie the port not granted last wins (or D when fixed)
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef UMEM_ARB_FIXED_PRIO_EN
      2'b11:   grant = 2'b01;
`else
      2'b11:   grant = (last == PORT_F) ? 2'b01 : 2'b10;
`endif
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/umem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory between LSU (D) and fetch (F).
// Build option: UMEM_ARB_FIXED_PRIO_EN (fixed D priority instead of round-robin).
module umem_arbiter
  import umem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_d_req,
  input  logic          i_d_wren,
  input  logic [AW-1:0] i_d_addr,
  input  logic [31:0]   i_d_wdata,
  input  logic [3:0]    i_d_bmask,
  output logic          o_d_gnt,
  output logic          o_d_rvld,
  output logic [31:0]   o_d_rdata,
  input  logic          i_f_req,
  input  logic [AW-1:0] i_f_addr,
  output logic          o_f_gnt,
  output logic          o_f_rvld,
  output logic [31:0]   o_f_rdata,
  output logic          o_mem_en,
  output logic          o_mem_wren,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic [31:0]   i_mem_rdata
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("umem_arbiter: MEM_LAT must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             winner;
  logic             last;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             done;

  // Grants are only offered while idle and never during a reset cycle
  assign req  = ((state == S_IDLE) && !i_reset) ? {i_f_req, i_d_req} : 2'b00;
  assign done = (state == S_WAIT) && (cnt == 4'd1);

  arb_rr2 u_pick (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  assign o_d_gnt = grant[0];
  assign o_f_gnt = grant[1];

  // Memory bus driven straight from the winning requester in the issue cycle
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_wren  = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = 32'h0000_0000;
    o_mem_bmask = 4'h0;
    if (grant[0]) begin
      o_mem_en    = 1'b1;
      o_mem_wren  = i_d_wren;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
      o_mem_bmask = i_d_bmask;
    end else if (grant[1]) begin
      o_mem_en    = 1'b1;
      o_mem_wren  = 1'b0;
      o_mem_addr  = i_f_addr;
      o_mem_wdata = 32'h0000_0000;
      o_mem_bmask = 4'h0;
    end else begin
      o_mem_en    = 1'b0;
      o_mem_wren  = 1'b0;
    end
  end

  // Next state and latency countdown
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (|grant) begin
          state_nxt = S_WAIT;
          cnt_nxt   = LAT_LOAD;
        end else begin
          state_nxt = S_IDLE;
          cnt_nxt   = cnt;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, winner/pointer and response registers; reset drops any transaction in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      winner    <= PORT_D;
      last      <= PORT_F;
      o_d_rvld  <= 1'b0;
      o_f_rvld  <= 1'b0;
      o_d_rdata <= 32'h0000_0000;
      o_f_rdata <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_d_rvld <= done && (winner == PORT_D);
      o_f_rvld <= done && (winner == PORT_F);
      if (|grant) begin
        winner <= grant[1] ? PORT_F : PORT_D;
        last   <= grant[1] ? PORT_F : PORT_D;
      end
      if (done && (winner == PORT_D)) begin
        o_d_rdata <= i_mem_rdata;
      end
      if (done && (winner == PORT_F)) begin
        o_f_rdata <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// Bench for umem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) run the same request tables.
module tb_umem_arbiter;

  localparam int AW = 32;

  typedef struct {
    int          start;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } item_t;

  logic  clk = 1'b0;
  logic  reset;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    armed = 1'b0;
  bit    fin = 1'b0;
  item_t dtab[$];
  item_t ftab[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Contents the bench memory returns for a read of address a
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input int lat, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL L%0d %s @cycle %0d: got %h expected %h", lat, name, cyc, act, exp);
    end
  endtask

  task automatic cmp_log(input int lat, input string name, input int act[$], input int exp[$]);
    checks++;
    if (act.size() != exp.size()) begin
      errors++;
      $display("FAIL L%0d %s: got %0d events expected %0d", lat, name, act.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < act.size(); k++) begin
      checks++;
      if (act[k] != exp[k]) begin
        errors++;
        $display("FAIL L%0d %s[%0d]: got cycle %0d expected cycle %0d", lat, name, k, act[k], exp[k]);
      end
    end
  endtask

  task automatic add(input bit is_f, input int start, input logic wren, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] bmask);
    item_t it;
    it.start = start; it.wren = wren; it.addr = addr; it.wdata = wdata; it.bmask = bmask;
    if (is_f) ftab.push_back(it);
    else dtab.push_back(it);
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_i
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic          d_req, d_wren, d_gnt, d_rvld;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic [3:0]    d_bmask;
    logic          f_req, f_gnt, f_rvld;
    logic [AW-1:0] f_addr;
    logic [31:0]   f_rdata;
    logic          mem_en, mem_wren;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_bmask;
    logic [15:0]   pv = 16'h0000;
    logic [31:0]   pa [16];
    int            gd[$], gf[$], rd[$], rf[$];
    logic [31:0]   first_frdata, wr_addr, wr_data;
    logic [3:0]    wr_mask;
    int            nwrites;
    bit            got_first_f;

    umem_arbiter #(.MEM_LAT(LAT), .AW(AW)) u_dut (
      .i_clk(clk), .i_reset(reset),
      .i_d_req(d_req), .i_d_wren(d_wren), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .i_d_bmask(d_bmask), .o_d_gnt(d_gnt), .o_d_rvld(d_rvld), .o_d_rdata(d_rdata),
      .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt), .o_f_rvld(f_rvld), .o_f_rdata(f_rdata),
      .o_mem_en(mem_en), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
    );

    // Fixed-latency memory: data for an access issued in cycle T is presented in cycle T+LAT
    always @(negedge clk) begin
      pv <= {pv[14:0], mem_en};
      pa[0] <= mem_addr;
      for (int k = 1; k < 16; k++) pa[k] <= pa[k-1];
    end
    assign mem_rdata = pv[LAT] ? memf(pa[LAT]) : 32'hBADB_AD00;

    initial begin : drv_d
      int di;
      bit g;
      di = 0;
      d_req = 1'b0; d_wren = 1'b0; d_addr = '0; d_wdata = 32'h0; d_bmask = 4'h0;
      forever begin
        @(negedge clk);
        g = d_gnt;
        @(posedge clk);
        #1;
        if (g) di++;
        if (di < dtab.size() && dtab[di].start <= cyc) begin
          d_req = 1'b1; d_wren = dtab[di].wren; d_addr = dtab[di].addr;
          d_wdata = dtab[di].wdata; d_bmask = dtab[di].bmask;
        end else begin
          d_req = 1'b0;
        end
      end
    end

    initial begin : drv_f
      int fi;
      bit g;
      fi = 0;
      f_req = 1'b0; f_addr = '0;
      forever begin
        @(negedge clk);
        g = f_gnt;
        @(posedge clk);
        #1;
        if (g) fi++;
        if (fi < ftab.size() && ftab[fi].start <= cyc) begin
          f_req = 1'b1; f_addr = ftab[fi].addr;
        end else begin
          f_req = 1'b0;
        end
      end
    end

    // Transaction-level model: memory is free from busy_until on; one response scheduled at resp_cyc
    initial begin : model
      int          busy_until, resp_cyc;
      logic        resp_port, last_f, e_dg, e_fg;
      logic [31:0] resp_data, exp_drd, exp_frd;
      busy_until = 0; resp_cyc = -1; resp_port = 1'b0; last_f = 1'b1;
      resp_data = 32'h0; exp_drd = 32'h0; exp_frd = 32'h0;
      first_frdata = 32'h0; nwrites = 0; got_first_f = 1'b0;
      wr_addr = 32'h0; wr_data = 32'h0; wr_mask = 4'h0;
      forever begin
        @(negedge clk);
        if (armed) begin
          if (resp_cyc == cyc) begin
            if (resp_port) exp_frd = resp_data;
            else exp_drd = resp_data;
          end
          chk(LAT, "d_rvld", {31'h0, d_rvld}, {31'h0, (resp_cyc == cyc) && !resp_port});
          chk(LAT, "f_rvld", {31'h0, f_rvld}, {31'h0, (resp_cyc == cyc) && resp_port});
          chk(LAT, "d_rdata", d_rdata, exp_drd);
          chk(LAT, "f_rdata", f_rdata, exp_frd);
          e_dg = 1'b0;
          e_fg = 1'b0;
          if (cyc >= busy_until && !reset) begin
            if (d_req && f_req) begin
`ifdef UMEM_ARB_FIXED_PRIO_EN
              e_dg = 1'b1;
`else
              e_dg = last_f;
              e_fg = !last_f;
`endif
            end else begin
              e_dg = d_req;
              e_fg = f_req;
            end
          end
          chk(LAT, "d_gnt", {31'h0, d_gnt}, {31'h0, e_dg});
          chk(LAT, "f_gnt", {31'h0, f_gnt}, {31'h0, e_fg});
          chk(LAT, "mem_en", {31'h0, mem_en}, {31'h0, e_dg | e_fg});
          if (!(e_dg || e_fg)) begin
            chk(LAT, "idle_wren", {31'h0, mem_wren}, 32'h0);
            chk(LAT, "idle_bmask", {28'h0, mem_bmask}, 32'h0);
          end
          if (e_dg) begin
            chk(LAT, "d_mem_addr", mem_addr, d_addr);
            chk(LAT, "d_mem_wren", {31'h0, mem_wren}, {31'h0, d_wren});
            chk(LAT, "d_mem_bmask", {28'h0, mem_bmask}, {28'h0, d_bmask});
            if (d_wren) chk(LAT, "d_mem_wdata", mem_wdata, d_wdata);
          end
          if (e_fg) begin
            chk(LAT, "f_mem_addr", mem_addr, f_addr);
            chk(LAT, "f_mem_wren", {31'h0, mem_wren}, 32'h0);
            chk(LAT, "f_mem_bmask", {28'h0, mem_bmask}, 32'h0);
          end
          if (e_dg || e_fg) begin
            busy_until = cyc + LAT + 1;
            resp_cyc   = cyc + LAT + 1;
            resp_port  = e_fg;
            resp_data  = memf(e_fg ? f_addr : d_addr);
            last_f     = e_fg;
          end
          if (reset) begin
            busy_until = cyc + 1;
            if (resp_cyc > cyc) resp_cyc = -1;
            exp_drd = 32'h0;
            exp_frd = 32'h0;
            last_f  = 1'b1;
          end
          if (d_gnt) gd.push_back(cyc);
          if (f_gnt) gf.push_back(cyc);
          if (d_rvld) rd.push_back(cyc);
          if (f_rvld) rf.push_back(cyc);
          if (f_rvld && !got_first_f) begin
            first_frdata = f_rdata;
            got_first_f  = 1'b1;
          end
          if (mem_en && mem_wren) begin
            nwrites++;
            wr_addr = mem_addr; wr_data = mem_wdata; wr_mask = mem_bmask;
          end
        end
      end
    end

    initial begin : final_chk
      int egd[$], egf[$], erd[$], erf[$];
      wait (fin);
      if (LAT == 1) begin
`ifdef UMEM_ARB_FIXED_PRIO_EN
        egd = '{10, 20, 22, 30, 32, 34, 60}; egf = '{2, 36, 38, 40, 62};
        erd = '{12, 24, 32, 34, 36, 62};     erf = '{4, 38, 40, 42, 64};
`else
        egd = '{10, 20, 22, 30, 34, 38, 60}; egf = '{2, 32, 36, 40, 62};
        erd = '{12, 24, 32, 36, 40, 62};     erf = '{4, 34, 38, 42, 64};
`endif
      end else begin
`ifdef UMEM_ARB_FIXED_PRIO_EN
        egd = '{10, 20, 22, 30, 34, 38, 60}; egf = '{2, 42, 46, 50, 64};
        erd = '{14, 26, 34, 38, 42, 64};     erf = '{6, 46, 50, 54, 68};
`else
        egd = '{10, 20, 22, 30, 38, 46, 60}; egf = '{2, 34, 42, 50, 64};
        erd = '{14, 26, 34, 42, 50, 64};     erf = '{6, 38, 46, 54, 68};
`endif
      end
      cmp_log(LAT, "d_gnt_cycles", gd, egd);
      cmp_log(LAT, "f_gnt_cycles", gf, egf);
      cmp_log(LAT, "d_rvld_cycles", rd, erd);
      cmp_log(LAT, "f_rvld_cycles", rf, erf);
      chk(LAT, "first_f_rdata", first_frdata, 32'h0050_0093);
      chk(LAT, "write_count", 32'(nwrites), 32'd1);
      chk(LAT, "write_addr", wr_addr, 32'h0000_2000);
      chk(LAT, "write_data", wr_data, 32'hDEAD_BEEF);
      chk(LAT, "write_bmask", {28'h0, wr_mask}, 32'h0000_000F);
    end
  end

  initial begin
    reset = 1'b1;
    add(1'b1, 2,  1'b0, 32'h0000_0000, 32'h0, 4'h0);
    add(1'b0, 10, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
    add(1'b0, 20, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    add(1'b0, 22, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      add(1'b0, 30, 1'b0, 32'h0000_0200 + 32'(4 * k), 32'h0, 4'h0);
      add(1'b1, 30, 1'b0, 32'h0000_0300 + 32'(4 * k), 32'h0, 4'h0);
    end
    add(1'b0, 60, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    add(1'b1, 61, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    at_cycle(1);
    armed = 1'b1;
    at_cycle(2);
    reset = 1'b0;
    at_cycle(21);
    reset = 1'b1;
    at_cycle(22);
    reset = 1'b0;
    at_cycle(28);
    reset = 1'b1;
    at_cycle(29);
    reset = 1'b0;
    at_cycle(75);
    fin = 1'b1;
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
